multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Moore control FSM for the multicycle RV32I core. It sits directly upstream of the ALU decoder and drives its 2-bit ALUOp input.
- It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- It generates all datapath mux selects and write enables, and stalls on a memory-ready handshake.

Parameters:
- MEM_WAIT_EN, 1, when 1 FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; when 0 mem_ready is ignored (treated as 1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instruction opcode (Instr[6:0]) from the instruction register
- mem_ready  input  1  memory access completes this cycle
- ALUOp  output  2  to ALU decoder: 00 add, 01 sub (branch), 10 funct-decoded
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 register A
- ALUSrcB  output  2  00 register WriteData, 01 ImmExt, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  output  1  0 PC, 1 Result
- IRWrite  output  1  load instruction register and OldPC
- PCUpdate  output  1  unconditional PC write
- Branch  output  1  conditional PC write (datapath ANDs with Zero)
- RegWrite  output  1  register file write
- MemWrite  output  1  data memory write
- illegal_op  output  1  one-cycle pulse on an unsupported opcode in DECODE
- state  output  4  current state code, for debug

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 go to FETCH on the next edge, with all enables 0.
- Reset: on a clk edge with reset=1, state becomes FETCH. While reset=1, IRWrite, PCUpdate, Branch, RegWrite, MemWrite and illegal_op are forced to 0, and the select outputs take their FETCH values. A reset in any state, including MEMREAD or MEMWRITE, aborts with no write. FETCH is the first active cycle after reset is released.
- Outputs are decoded from state only, except that the enables below are gated by mem_ready. Any output not listed for a state is 0.
- Transitions and outputs per state:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Next state DECODE if mem_ready, else FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> FETCH, with illegal_op=1 for this cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next state MEMWB if mem_ready, else hold.
  - MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=mem_ready. Next state FETCH if mem_ready, else hold. MemWrite must be asserted for exactly one cycle.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- op is sampled every cycle. It must remain stable from DECODE until the instruction returns to FETCH; the IR guarantees this.
- Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, jal 4. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- RegWrite, MemWrite and IRWrite are never asserted in the same cycle.

Test Plan:
- Reset, then op=0110011 with mem_ready=1 -> states 0,1,6,8,0. ALUOp=10 in EXECUTER. RegWrite=1 only in ALUWB.
- op=0000011 -> states 0,1,2,3,4,0. AdrSrc=1 in MEMREAD. ResultSrc=01 and RegWrite=1 in MEMWB. Then repeat with mem_ready=0 for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, total 7 cycles.
- op=0100011, with mem_ready low in the first MEMWRITE cycle and high in the second -> MemWrite=1 for exactly one cycle (the second), then FETCH.
- op=1100011 -> states 0,1,9,0. ALUOp=01 and Branch=1 in BEQ. op=1101111 -> states 0,1,10,8,0. PCUpdate=1 in JAL.
- mem_ready=0 for 3 cycles in FETCH -> state stays 0 and IRWrite/PCUpdate stay 0. Both go to 1 only in the cycle mem_ready=1.
- op=1111111 in DECODE -> illegal_op=1 for one cycle, then FETCH. Separately, reset=1 during MEMREAD -> state=0 next cycle with RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Moore main control FSM for the multicycle RV32I core.
// It sequences instruction phases and drives datapath selects, enables and ALUOp.
module multicycle_main_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_q;
    state_t state_d;
    logic   mem_go;

    assign mem_go = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_go ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_go ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Reset overrides the state decode so no write can leak out of an aborted access.
    always_comb begin
        ALUOp      = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        illegal_op = 1'b0;
        if (reset) begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_go;
                    PCUpdate  = mem_go;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    case (op)
                        OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal_op = 1'b0;
                        default:                                          illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = mem_go;
                end
                S_EXECUTER: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECUTEI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    PCUpdate = 1'b1;
                end
                default: begin
                    ALUOp = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: fixed scenarios plus random instruction
// streams compared against a phase-list model of each instruction.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b0;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal_op;
    logic [3:0] state;
    logic [14:0] outs;

    int checks = 0;
    int passes = 0;

    typedef int seq_t[$];

    localparam logic [14:0] RESET_OUTS = {2'b00, 2'b00, 2'b10, 2'b10, 7'b0};

    multicycle_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_op(illegal_op), .state(state)
    );

    assign outs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate,
                   Branch, RegWrite, MemWrite, illegal_op};

    always #5 clk = ~clk;

    // Each instruction is the list of state codes it visits, starting from FETCH.
    function automatic seq_t phases(input logic [6:0] opc);
        seq_t s;
        case (opc)
            7'b0000011: s = {0, 1, 2, 3, 4};
            7'b0100011: s = {0, 1, 2, 5};
            7'b0110011: s = {0, 1, 6, 8};
            7'b0010011: s = {0, 1, 7, 8};
            7'b1100011: s = {0, 1, 9};
            7'b1101111: s = {0, 1, 10, 8};
            default:    s = {0, 1};
        endcase
        return s;
    endfunction

    function automatic bit is_wait(input int p);
        return (p == 0) || (p == 3) || (p == 5);
    endfunction

    // Packed as {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal_op}.
    function automatic logic [14:0] exp_out(input int p, input bit rdy, input bit ill);
        case (p)
            0:  return {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, rdy, rdy, 4'b0000};
            1:  return {2'b00, 2'b01, 2'b01, 2'b00, 6'b000000, ill};
            2:  return {2'b00, 2'b10, 2'b01, 2'b00, 7'b0};
            3:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 6'b000000};
            4:  return {2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b1, 2'b00};
            5:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0000, rdy, 1'b0};
            6:  return {2'b10, 2'b10, 2'b00, 2'b00, 7'b0};
            7:  return {2'b10, 2'b10, 2'b01, 2'b00, 7'b0};
            8:  return {2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 2'b00};
            9:  return {2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b1, 3'b000};
            10: return {2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1, 4'b0000};
            default: return 15'd0;
        endcase
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            mem_ready = 1'b1;
            op = 7'b0000011;
            #1;
            checks++;
            if (state !== 4'd0) $display("[TB] FAIL reset_state got %0d exp 0", state);
            else passes++;
            checks++;
            if (outs !== RESET_OUTS) $display("[TB] FAIL reset_outs got %b exp %b", outs, RESET_OUTS);
            else passes++;
        end
    endtask

    task automatic test_sequences();
        logic [6:0] ops [8] = '{7'b0110011, 7'b0000011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110011, 7'b1111111};
        int fst [8] = '{0, 0, 0, 0, 0, 0, 3, 0};
        int mst [8] = '{0, 0, 2, 1, 0, 0, 0, 0};
        for (int t = 0; t < 8; t++) begin
            seq_t seq = phases(ops[t]);
            int   idx = 0;
            int   fs  = fst[t];
            int   ms  = mst[t];
            bit   ill = (seq.size() == 2);
            bit   rdy;
            while (idx < seq.size()) begin
                int p = seq[idx];
                if (p == 0) begin
                    rdy = (fs == 0);
                    if (!rdy) fs--;
                end else if (p == 3 || p == 5) begin
                    rdy = (ms == 0);
                    if (!rdy) ms--;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                reset = 1'b0;
                mem_ready = rdy;
                op = ops[t];
                #1;
                checks++;
                if (state !== 4'(p)) $display("[TB] FAIL seq_state op=%b got %0d exp %0d", ops[t], state, p);
                else passes++;
                checks++;
                if (outs !== exp_out(p, rdy, ill && p == 1))
                    $display("[TB] FAIL seq_outs op=%b state=%0d got %b exp %b", ops[t], p, outs, exp_out(p, rdy, ill && p == 1));
                else passes++;
                if (!(is_wait(p) && !rdy)) idx++;
            end
        end
    endtask

    task automatic test_reset_in_memread();
        int exp_states [4] = '{0, 1, 2, 3};
        bit rdys [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = 1'b0;
            mem_ready = rdys[i];
            op = 7'b0000011;
            #1;
            checks++;
            if (state !== 4'(exp_states[i])) $display("[TB] FAIL abort_pre_state got %0d exp %0d", state, exp_states[i]);
            else passes++;
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== RESET_OUTS) $display("[TB] FAIL abort_outs got %b exp %b", outs, RESET_OUTS);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0) $display("[TB] FAIL abort_state got %0d exp 0", state);
        else passes++;
        checks++;
        if (outs !== exp_out(0, 1'b0, 1'b0)) $display("[TB] FAIL abort_fetch_outs got %b exp %b", outs, exp_out(0, 1'b0, 1'b0));
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] pool [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1111111};
        for (int n = 0; n < 60; n++) begin
            logic [6:0] opc = ($urandom_range(0, 7) == 7) ? 7'($urandom) : pool[$urandom_range(0, 6)];
            seq_t seq = phases(opc);
            int   idx = 0;
            bit   ill = (seq.size() == 2);
            bit   rdy;
            while (idx < seq.size()) begin
                int p = seq[idx];
                rdy = is_wait(p) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                @(negedge clk);
                reset = 1'b0;
                mem_ready = rdy;
                op = opc;
                #1;
                checks++;
                if (state !== 4'(p)) $display("[TB] FAIL rand_state op=%b got %0d exp %0d", opc, state, p);
                else passes++;
                checks++;
                if (outs !== exp_out(p, rdy, ill && p == 1))
                    $display("[TB] FAIL rand_outs op=%b state=%0d got %b exp %b", opc, p, outs, exp_out(p, rdy, ill && p == 1));
                else passes++;
                if (!(is_wait(p) && !rdy)) idx++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_reset_in_memread();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout got running exp finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
